rx_credit_fifo: RTL and testbench
=================================

# rx_credit_fifo

Receive-side character buffer and flow-control credit keeper for the SpaceWire link. It sits directly downstream of the receiver: it stores each received N-Char (`rx_data_flag` qualified by `rx_buffer_write`), tracks the credit advertised to the far end, requests FCT transmission when buffer space allows, and flags credit violations. The upstream stage delivers write pulses already synchronous to `posedge_clk`.

## Interface
Parameters:
- `DEPTH`, 64: FIFO entries; power of two, ≥ 64.
- `AW`, 6: log2(DEPTH).
- `MAX_CREDIT`, 56: ceiling on outstanding credit (7 FCTs).

Ports:
- `posedge_clk`  in  1  single clock.
- `rx_resetn`  in  1  synchronous, active-low reset.
- `link_run`  in  1  link FSM in Run; low clears credit state.
- `rx_buffer_write`  in  1  one-cycle pulse; `rx_data_flag` valid.
- `rx_data_flag`  in  9  bit 8 = control flag; `1_00000000` = EOP, `1_00000001` = EEP.
- `rd_en`  in  1  consumer pop request.
- `rd_data`  out  9  head entry, first-word-fall-through.
- `rd_valid`  out  1  FIFO not empty.
- `fifo_count`  out  AW+1  current occupancy.
- `fct_req`  out  1  level request to the transmitter to send one FCT.
- `fct_ack`  in  1  one-cycle pulse: FCT sent.
- `credit`  out  6  outstanding credit C.
- `credit_error`  out  1  sticky credit or overflow violation.

## Operation
- Storage: register array `mem[DEPTH]`, write pointer `wp`, read pointer `rp` (AW bits, wrap modulo DEPTH), `fifo_count` 0..DEPTH.
- `rd_data = mem[rp]` combinational. Pop when `rd_en && rd_valid`. `rd_en` on empty is ignored; pointers are unchanged.
- Accepted write: `rx_buffer_write && link_run && C != 0 && count != DEPTH`. The entry is stored, `wp++`, and C decrements by 1.
- Violation: `rx_buffer_write` with `C == 0` or count == DEPTH. The character is dropped and `credit_error` is set. It stays set until reset or `link_run` low.
- Writes with `link_run` low are dropped silently.
- Simultaneous push and pop: both happen and count is unchanged. Pop on full plus push is legal.
- Credit arithmetic (6-bit, never wraps): `C_next = C + 8·(fct_ack && fct_req) − accepted_write`.
- An `fct_ack` without `fct_req` is ignored.
- `fct_req_next = link_run && (C_next + 8 ≤ MAX_CREDIT) && (DEPTH − count_next ≥ C_next + 8)`. Buffer space is always reserved for every credit granted.
- `link_run` low: C ← 0, `fct_req` ← 0, `credit_error` ← 0. FIFO contents are retained.

## Timing
- Reset values, all outputs: `fct_req=0`, `credit=0`, `credit_error=0`, `fifo_count=0`, `rd_valid=0`. `rd_data` is don't-care while `rd_valid=0`.
- Write to `rd_valid`: entry visible one cycle after the write pulse.
- Pop: `rp` advances on the pop edge; the next entry appears the following cycle.
- `fct_req` is registered and reflects the next-state equation one cycle after any change in C, count or `link_run`. It stays high in the `fct_ack` cycle.
- FCT handshake: the transmitter pulses `fct_ack` for exactly one cycle per FCT. It may ack in the same cycle `fct_req` rises.
- `credit_error` asserts the cycle after the offending write.
- Reset mid-operation: all state returns to reset values on the next edge, and FIFO contents are discarded.

## Configuration
- `RX_CREDIT_FIFO_EEP_INSERT_EN` defined:
  - A falling edge of `link_run` sets a pending flag.
  - While pending and count < DEPTH, `1_00000001` (EEP) is pushed, bypassing credit, and the flag is cleared.
  - A concurrent upstream write on that cycle is dropped. It cannot legally occur, since `link_run` is low.
- Not defined: a `link_run` fall inserts nothing; the FIFO is left as is.

## Test plan
- Reset, `link_run=1`, no traffic: `fct_req` rises 1 cycle later. Ack 7 times: `credit=56`, `fct_req=0`.
- Credit 8; write 8 chars `0x00..0x07` → `credit=0`, `fifo_count=8`. A 9th write sets `credit_error=1`, leaves `fifo_count=8`, and the 9th char is not stored.
- DEPTH=64, credit 56, fill 56 with no reads: `fct_req` stays 0 while credit ≥ 49. After 8 pops with 48 in the FIFO, FCT re-request condition holds and `fct_req=1`.
- Same-cycle `fct_ack` and accepted write at C=3 → `credit=10`. Same-cycle push and pop at count 5 → count 5, head advances.
- Pop-order check: write `0x41, 0x42, 1_00000000` and read back in order. `rd_en` on empty leaves count 0 and raises no error.
- With `RX_CREDIT_FIFO_EEP_INSERT_EN` defined: 3 entries stored, drop `link_run` → count 4, last entry `1_00000001`, `credit=0`, `fct_req=0`. Without the macro, count stays 3.

Source files
------------

// File: rtl/rx_credit_fifo.sv
// Receive character FIFO and FCT credit keeper for a SpaceWire link.
// Optional EEP insertion on link loss is enabled by defining RX_CREDIT_FIFO_EEP_INSERT_EN.
module rx_credit_fifo #(
    parameter int DEPTH      = 64,
    parameter int AW         = 6,
    parameter int MAX_CREDIT = 56
) (
    input  logic          posedge_clk,
    input  logic          rx_resetn,
    input  logic          link_run,
    input  logic          rx_buffer_write,
    input  logic [8:0]    rx_data_flag,
    input  logic          rd_en,
    output logic [8:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   fifo_count,
    output logic          fct_req,
    input  logic          fct_ack,
    output logic [5:0]    credit,
    output logic          credit_error
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [8:0]  EEP_CHAR   = 9'h101;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic [5:0]    credit_q;
    logic [5:0]    credit_next;
    logic          req_q;
    logic          req_next;
    logic          err_q;
    logic          full;
    logic          pop;
    logic          push;
    logic          ack_ok;
    logic          acc_write;
    logic          bad_write;
    logic          insert;
    logic [8:0]    push_data;
    logic [31:0]   free_next;
    logic [31:0]   need_next;

`ifdef RX_CREDIT_FIFO_EEP_INSERT_EN
    logic link_run_q;
    logic pending;

    // Remember a link loss until there is room to mark the packet as errored.
    always_ff @(posedge posedge_clk) begin
        if (!rx_resetn) begin
            link_run_q <= 1'b0;
            pending    <= 1'b0;
        end else begin
            link_run_q <= link_run;
            if (link_run_q && !link_run) begin
                pending <= 1'b1;
            end else if (insert) begin
                pending <= 1'b0;
            end
        end
    end

    assign insert = pending && !full;
`else
    assign insert = 1'b0;
`endif

    always_comb begin
        full      = (count == FULL_COUNT);
        pop       = rd_en && (count != '0);
        ack_ok    = fct_ack && req_q;
        acc_write = rx_buffer_write && link_run && (credit_q != 6'd0) && !full && !insert;
        bad_write = rx_buffer_write && link_run && ((credit_q == 6'd0) || full) && !insert;
        push      = acc_write || insert;
        push_data = insert ? EEP_CHAR : rx_data_flag;

        count_next = count + (AW+1)'(push) - (AW+1)'(pop);

        credit_next = 6'd0;
        if (link_run) begin
            credit_next = credit_q + (ack_ok ? 6'd8 : 6'd0) - (acc_write ? 6'd1 : 6'd0);
        end

        // Only request another FCT if the buffer can hold every character it would authorise.
        free_next = 32'(DEPTH) - 32'(count_next);
        need_next = 32'(credit_next) + 32'd8;
        req_next  = link_run && (need_next <= 32'(MAX_CREDIT)) && (free_next >= need_next);
    end

    always_ff @(posedge posedge_clk) begin
        if (!rx_resetn) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            credit_q <= 6'd0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            count    <= count_next;
            credit_q <= credit_next;
            req_q    <= req_next;
            if (!link_run) begin
                err_q <= 1'b0;
            end else if (bad_write) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge posedge_clk) begin
        if (rx_resetn && push) begin
            mem[wp] <= push_data;
        end
    end

    assign rd_data      = mem[rp];
    assign rd_valid     = (count != '0);
    assign fifo_count   = count;
    assign fct_req      = req_q;
    assign credit       = credit_q;
    assign credit_error = err_q;

endmodule

// File: tb/tb_rx_credit_fifo.sv
// Directed bench for rx_credit_fifo: a per-cycle vector table plus hand-written sequences.
module tb_rx_credit_fifo;

    typedef struct {
        logic       lr;
        logic       wr;
        logic [8:0] d;
        logic       rd;
        logic       ack;
        logic [6:0] n;
        logic [5:0] c;
        logic       req;
        logic       err;
        logic       vld;
        logic [8:0] head;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       lr;
    logic       wr;
    logic [8:0] din;
    logic       rd;
    logic       ack;
    logic [8:0] rd_data;
    logic       rd_valid;
    logic [6:0] fifo_count;
    logic       fct_req;
    logic [5:0] credit;
    logic       credit_error;

    int n_chk  = 0;
    int n_fail = 0;

    vec_t tbl [21];

    always #5 clk = ~clk;

    rx_credit_fifo #(.DEPTH(64), .AW(6), .MAX_CREDIT(56)) dut (
        .posedge_clk     (clk),
        .rx_resetn       (rstn),
        .link_run        (lr),
        .rx_buffer_write (wr),
        .rx_data_flag    (din),
        .rd_en           (rd),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .fifo_count      (fifo_count),
        .fct_req         (fct_req),
        .fct_ack         (ack),
        .credit          (credit),
        .credit_error    (credit_error)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later, drop pulses.
    task automatic tick(input logic w, input logic [8:0] d, input logic r, input logic a);
        wr  = w;
        din = d;
        rd  = r;
        ack = a;
        @(posedge clk);
        #1;
        wr  = 1'b0;
        rd  = 1'b0;
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        lr   = 1'b0;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        rstn = 1'b1;
    endtask

    task automatic chk_state(input string tag, input logic [6:0] n, input logic [5:0] c,
                             input logic req, input logic err);
        chk({tag, ".count"}, 32'(fifo_count), 32'(n));
        chk({tag, ".credit"}, 32'(credit), 32'(c));
        chk({tag, ".req"}, 32'(fct_req), 32'(req));
        chk({tag, ".err"}, 32'(credit_error), 32'(err));
    endtask

    initial begin
        // Link up, one FCT, eight accepted writes, one violation, drain, over-read, link down.
        tbl[0] = '{1'b1, 1'b0, 9'h0, 1'b0, 1'b0, 7'd0, 6'd0, 1'b1, 1'b0, 1'b0, 9'h0};
        tbl[1] = '{1'b1, 1'b0, 9'h0, 1'b0, 1'b1, 7'd0, 6'd8, 1'b1, 1'b0, 1'b0, 9'h0};
        for (int k = 0; k < 8; k++) begin
            tbl[2+k] = '{1'b1, 1'b1, 9'(k), 1'b0, 1'b0, 7'(k+1), 6'(7-k), 1'b1, 1'b0, 1'b1, 9'h0};
        end
        tbl[10] = '{1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0, 7'd8, 6'd0, 1'b1, 1'b1, 1'b1, 9'h0};
        for (int j = 0; j < 8; j++) begin
            tbl[11+j] = '{1'b1, 1'b0, 9'h0, 1'b1, 1'b0, 7'(7-j), 6'd0, 1'b1, 1'b1,
                          (j < 7), 9'(j+1)};
        end
        tbl[19] = '{1'b1, 1'b0, 9'h0, 1'b1, 1'b0, 7'd0, 6'd0, 1'b1, 1'b1, 1'b0, 9'h0};
        tbl[20] = '{1'b0, 1'b0, 9'h0, 1'b0, 1'b0, 7'd0, 6'd0, 1'b0, 1'b0, 1'b0, 9'h0};

        wr = 1'b0; din = 9'h0; rd = 1'b0; ack = 1'b0;
        do_reset();
        chk_state("reset", 7'd0, 6'd0, 1'b0, 1'b0);
        chk("reset.valid", 32'(rd_valid), 32'd0);

        for (int i = 0; i < 21; i++) begin
            lr = tbl[i].lr;
            tick(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].ack);
            chk_state($sformatf("vec%0d", i), tbl[i].n, tbl[i].c, tbl[i].req, tbl[i].err);
            chk($sformatf("vec%0d.valid", i), 32'(rd_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("vec%0d.head", i), 32'(rd_data), 32'(tbl[i].head));
            end
        end

        // Grant the full 56 credits, then fill without reading.
        do_reset();
        lr = 1'b1;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, 9'h0, 1'b0, 1'b1);
        end
        chk_state("grant56", 7'd0, 6'd56, 1'b0, 1'b0);
        for (int k = 0; k < 56; k++) begin
            tick(1'b1, 9'(k), 1'b0, 1'b0);
            chk($sformatf("fill%0d.req", k), 32'(fct_req), 32'(k >= 7));
        end
        chk_state("fill_done", 7'd56, 6'd0, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 9'h0, 1'b1, 1'b0);
        end
        chk_state("pop8", 7'd48, 6'd0, 1'b1, 1'b0);
        chk("pop8.head", 32'(rd_data), 32'h8);

        // Ack coincident with a write, then push and pop together.
        do_reset();
        lr = 1'b1;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        tick(1'b0, 9'h0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 9'(16+k), 1'b0, 1'b0);
        end
        chk_state("c3", 7'd5, 6'd3, 1'b1, 1'b0);
        tick(1'b1, 9'h15, 1'b0, 1'b1);
        chk_state("ack_wr", 7'd6, 6'd10, 1'b1, 1'b0);
        tick(1'b0, 9'h0, 1'b1, 1'b0);
        chk("pop1.head", 32'(rd_data), 32'h11);
        tick(1'b1, 9'h16, 1'b1, 1'b0);
        chk_state("push_pop", 7'd5, 6'd9, 1'b1, 1'b0);
        chk("push_pop.head", 32'(rd_data), 32'h12);
        rstn = 1'b0;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        rstn = 1'b1;
        chk_state("mid_reset", 7'd0, 6'd0, 1'b0, 1'b0);
        chk("mid_reset.valid", 32'(rd_valid), 32'd0);

        // Pop order including an EOP marker, then reads on empty.
        lr = 1'b1;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        tick(1'b0, 9'h0, 1'b0, 1'b1);
        tick(1'b1, 9'h041, 1'b0, 1'b0);
        tick(1'b1, 9'h042, 1'b0, 1'b0);
        tick(1'b1, 9'h100, 1'b0, 1'b0);
        chk("order.h0", 32'(rd_data), 32'h41);
        tick(1'b0, 9'h0, 1'b1, 1'b0);
        chk("order.h1", 32'(rd_data), 32'h42);
        tick(1'b0, 9'h0, 1'b1, 1'b0);
        chk("order.h2", 32'(rd_data), 32'h100);
        tick(1'b0, 9'h0, 1'b1, 1'b0);
        tick(1'b0, 9'h0, 1'b1, 1'b0);
        tick(1'b0, 9'h0, 1'b1, 1'b0);
        chk_state("empty_rd", 7'd0, 6'd5, 1'b1, 1'b0);
        chk("empty_rd.valid", 32'(rd_valid), 32'd0);

        // Link loss with three entries buffered.
        do_reset();
        lr = 1'b1;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        tick(1'b0, 9'h0, 1'b0, 1'b1);
        tick(1'b1, 9'h0A1, 1'b0, 1'b0);
        tick(1'b1, 9'h0A2, 1'b0, 1'b0);
        tick(1'b1, 9'h0A3, 1'b0, 1'b0);
        lr = 1'b0;
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        tick(1'b0, 9'h0, 1'b0, 1'b0);
        tick(1'b0, 9'h0, 1'b0, 1'b0);
`ifdef RX_CREDIT_FIFO_EEP_INSERT_EN
        chk_state("link_down", 7'd4, 6'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 9'h0, 1'b1, 1'b0);
        end
        chk("link_down.eep", 32'(rd_data), 32'h101);
`else
        chk_state("link_down", 7'd3, 6'd0, 1'b0, 1'b0);
        chk("link_down.head", 32'(rd_data), 32'hA1);
`endif
        tick(1'b1, 9'h0B0, 1'b0, 1'b0);
        chk("dead_wr.err", 32'(credit_error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
